scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux.sv | 151 +++++++++++++++
 tb/tb_scan_mux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Channel multiplexer with a manual select mode and a timed auto-scan mode.
// Define SCAN_MUX_MASK_EN to add the ChMask per-channel enable port.
module scan_mux #(
  parameter int NUM_CH = 7,
  parameter int WIDTH  = 1,
  parameter int DWELL  = 4,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          MuxSelect,
  input  logic [NUM_CH*WIDTH-1:0]   Input,
  input  logic                      Hold,
`ifdef SCAN_MUX_MASK_EN
  input  logic [NUM_CH-1:0]         ChMask,
`endif
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_W-1:0]          Channel,
  output logic                      Valid,
  output logic                      Wrap
);

  localparam int NUM_SLOT = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {INIT, MANUAL, SCAN} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  channel_q, channel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic [NUM_CH-1:0]   en_mask;
  logic [NUM_SLOT-1:0] en_slot;
  logic [WIDTH-1:0]    slot_data [NUM_SLOT];
  logic                any_en;
  logic [SEL_W-1:0]    man_idx;
  logic [SEL_W-1:0]    scan_next;
  logic                scan_wrap;
  logic                scan_found;
  logic [SEL_W-1:0]    cand;

`ifdef SCAN_MUX_MASK_EN
  assign en_mask = ChMask;
`else
  assign en_mask = '1;
`endif

  assign any_en = |en_mask;

  // Slots are padded to a power of two so any select value indexes safely;
  // disabled or nonexistent channels read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
      if (gi < NUM_CH) begin : g_ch
        assign slot_data[gi] = en_mask[gi] ? Input[gi*WIDTH +: WIDTH] : '0;
        assign en_slot[gi]   = en_mask[gi];
      end else begin : g_pad
        assign slot_data[gi] = '0;
        assign en_slot[gi]   = 1'b0;
      end
    end
  endgenerate

  assign man_idx = ({1'b0, MuxSelect} < (SEL_W+1)'(NUM_CH)) ? MuxSelect : '0;

  // Next enabled channel in ascending order; wrap flags a pass through the top.
  always_comb begin
    scan_next  = channel_q;
    scan_wrap  = 1'b0;
    scan_found = 1'b0;
    cand       = channel_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
      if (!scan_found && en_slot[cand]) begin
        scan_found = 1'b1;
        scan_next  = cand;
        scan_wrap  = (cand <= channel_q);
      end
    end
  end

  always_comb begin
    state_d   = Mode ? SCAN : MANUAL;
    channel_d = channel_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    case (state_d)
      MANUAL: begin
        channel_d = man_idx;
        cnt_d     = '0;
        out_d     = slot_data[man_idx];
        valid_d   = (state_q == MANUAL) && (man_idx == channel_q) && en_slot[man_idx];
      end
      SCAN: begin
        if (!any_en) begin
          channel_d = '0;
          cnt_d     = '0;
        end else if (state_q != SCAN) begin
          cnt_d = '0;
        end else if (!Hold) begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d     = '0;
            channel_d = scan_next;
            wrap_d    = scan_wrap;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        out_d   = slot_data[channel_d];
        valid_d = !Hold && (cnt_d == DWELL_LAST) && en_slot[channel_d];
      end
      default: begin
        channel_d = '0;
        cnt_d     = '0;
        out_d     = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= INIT;
      channel_q <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign Out     = out_q;
  assign Channel = channel_q;
  assign Valid   = valid_q;
  assign Wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: instance A (WIDTH=8, DWELL=4), instance B (WIDTH=1, DWELL=1).
module tb_scan_mux;

  logic       Clock = 1'b0;
  logic       Reset, Mode, Hold;
  logic [2:0] MuxSelect;
  logic [55:0] in_a;
  logic [6:0]  in_b;
  logic [7:0] out_a;
  logic [2:0] ch_a, ch_b;
  logic       valid_a, wrap_a, valid_b, wrap_b;
  logic [0:0] out_b;
`ifdef SCAN_MUX_MASK_EN
  logic [6:0] mask_a, mask_b;
`endif

  int errors = 0;
  int checks = 0;
  logic [6:0] pat_b = 7'b1010010;

  always #5 Clock = ~Clock;

  scan_mux #(.NUM_CH(7), .WIDTH(8), .DWELL(4)) dut_a (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .MuxSelect(MuxSelect),
    .Input(in_a), .Hold(Hold),
`ifdef SCAN_MUX_MASK_EN
    .ChMask(mask_a),
`endif
    .Out(out_a), .Channel(ch_a), .Valid(valid_a), .Wrap(wrap_a)
  );

  scan_mux #(.NUM_CH(7), .WIDTH(1), .DWELL(1)) dut_b (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .MuxSelect(MuxSelect),
    .Input(in_b), .Hold(Hold),
`ifdef SCAN_MUX_MASK_EN
    .ChMask(mask_b),
`endif
    .Out(out_b), .Channel(ch_b), .Valid(valid_b), .Wrap(wrap_b)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic init_inputs();
    for (int k = 0; k < 7; k++) in_a[k*8 +: 8] = 8'hA0 + 8'(k);
    in_b = pat_b;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Mode = 1'b0; Hold = 1'b0; MuxSelect = 3'd3;
    Reset = 1'b1;
    tick();
    checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL reset_out_a: got %h expected 00", out_a); end
    checks++; if (ch_a !== 3'd0) begin errors++; $display("FAIL reset_ch_a: got %0d expected 0", ch_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap_a: got %b expected 0", wrap_a); end
    checks++; if (out_b !== 1'b0) begin errors++; $display("FAIL reset_out_b: got %b expected 0", out_b); end
    $display("reset: out_a=%h ch_a=%0d valid_a=%b wrap_a=%b", out_a, ch_a, valid_a, wrap_a);
    Reset = 1'b0;
  endtask

  task automatic test_manual();
    Mode = 1'b0; MuxSelect = 3'd0;
    tick();
    for (int s = 0; s < 7; s++) begin
      MuxSelect = 3'(s);
      tick();
      checks++; if (out_b !== pat_b[s]) begin errors++; $display("FAIL manual_out_b sel=%0d: got %b expected %b", s, out_b, pat_b[s]); end
      checks++; if (ch_b !== 3'(s)) begin errors++; $display("FAIL manual_ch_b sel=%0d: got %0d expected %0d", s, ch_b, s); end
      checks++; if (out_a !== 8'hA0 + 8'(s)) begin errors++; $display("FAIL manual_out_a sel=%0d: got %h expected %h", s, out_a, 8'hA0 + 8'(s)); end
      if (s != 0) begin
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL manual_valid_change sel=%0d: got %b expected 0", s, valid_b); end
      end
      tick();
      checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL manual_valid_steady sel=%0d: got %b expected 1", s, valid_b); end
      $display("manual sel=%0d out_b=%b ch_b=%0d valid_b=%b out_a=%h", s, out_b, ch_b, valid_b, out_a);
    end
  endtask

  task automatic test_manual_oob();
    MuxSelect = 3'd7;
    tick();
    checks++; if (ch_a !== 3'd0) begin errors++; $display("FAIL oob_ch_a: got %0d expected 0", ch_a); end
    checks++; if (out_a !== 8'hA0) begin errors++; $display("FAIL oob_out_a: got %h expected a0", out_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL oob_valid_change: got %b expected 0", valid_a); end
    tick();
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL oob_valid_steady: got %b expected 1", valid_a); end
    checks++; if (ch_b !== 3'd0) begin errors++; $display("FAIL oob_ch_b: got %0d expected 0", ch_b); end
    $display("oob sel=7 ch_a=%0d out_a=%h valid_a=%b", ch_a, out_a, valid_a);
  endtask

  task automatic test_scan();
    int wraps = 0;
    int exp_ch;
    logic exp_valid, exp_wrap;
    Mode = 1'b1; Hold = 1'b0;
    pulse_reset();
    for (int n = 1; n <= 30; n++) begin
      tick();
      exp_ch    = ((n - 1) / 4) % 7;
      exp_valid = ((n - 1) % 4 == 3);
      exp_wrap  = (n > 1) && ((n - 1) % 4 == 0) && (exp_ch == 0);
      if (wrap_a === 1'b1) wraps++;
      checks++; if (ch_a !== 3'(exp_ch)) begin errors++; $display("FAIL scan_ch n=%0d: got %0d expected %0d", n, ch_a, exp_ch); end
      checks++; if (out_a !== 8'hA0 + 8'(exp_ch)) begin errors++; $display("FAIL scan_out n=%0d: got %h expected %h", n, out_a, 8'hA0 + 8'(exp_ch)); end
      checks++; if (valid_a !== exp_valid) begin errors++; $display("FAIL scan_valid n=%0d: got %b expected %b", n, valid_a, exp_valid); end
      checks++; if (wrap_a !== exp_wrap) begin errors++; $display("FAIL scan_wrap n=%0d: got %b expected %b", n, wrap_a, exp_wrap); end
      $display("scan n=%0d ch_a=%0d out_a=%h valid_a=%b wrap_a=%b", n, ch_a, out_a, valid_a, wrap_a);
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL scan_wrap_count: got %0d expected 1", wraps); end
  endtask

  task automatic test_hold();
    Mode = 1'b1; Hold = 1'b0;
    pulse_reset();
    for (int n = 1; n <= 6; n++) tick();
    checks++; if (ch_a !== 3'd1) begin errors++; $display("FAIL hold_pre_ch: got %0d expected 1", ch_a); end
    Hold = 1'b1;
    in_a[8 +: 8] = 8'h5A;
    for (int h = 0; h < 5; h++) begin
      tick();
      checks++; if (ch_a !== 3'd1) begin errors++; $display("FAIL hold_ch h=%0d: got %0d expected 1", h, ch_a); end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL hold_valid h=%0d: got %b expected 0", h, valid_a); end
      checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL hold_wrap h=%0d: got %b expected 0", h, wrap_a); end
      checks++; if (out_a !== 8'h5A) begin errors++; $display("FAIL hold_out h=%0d: got %h expected 5a", h, out_a); end
      $display("hold h=%0d ch_a=%0d out_a=%h valid_a=%b", h, ch_a, out_a, valid_a);
    end
    Hold = 1'b0;
    tick();
    checks++; if (ch_a !== 3'd1 || valid_a !== 1'b0) begin errors++; $display("FAIL hold_resume_cnt2: got ch=%0d valid=%b expected ch=1 valid=0", ch_a, valid_a); end
    tick();
    checks++; if (ch_a !== 3'd1 || valid_a !== 1'b1) begin errors++; $display("FAIL hold_resume_cnt3: got ch=%0d valid=%b expected ch=1 valid=1", ch_a, valid_a); end
    tick();
    checks++; if (ch_a !== 3'd2 || out_a !== 8'hA2 || valid_a !== 1'b0) begin errors++; $display("FAIL hold_resume_adv: got ch=%0d out=%h valid=%b expected ch=2 out=a2 valid=0", ch_a, out_a, valid_a); end
    in_a[8 +: 8] = 8'hA1;
  endtask

  task automatic test_reset_during_wrap();
    Mode = 1'b1; Hold = 1'b0;
    pulse_reset();
    for (int n = 1; n <= 29; n++) tick();
    checks++; if (wrap_a !== 1'b1 || ch_a !== 3'd0) begin errors++; $display("FAIL rwrap_pre: got wrap=%b ch=%0d expected wrap=1 ch=0", wrap_a, ch_a); end
    Reset = 1'b1;
    tick();
    checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL rwrap_out: got %h expected 00", out_a); end
    checks++; if (wrap_a !== 1'b0 || valid_a !== 1'b0 || ch_a !== 3'd0) begin errors++; $display("FAIL rwrap_flags: got wrap=%b valid=%b ch=%0d expected 0 0 0", wrap_a, valid_a, ch_a); end
    Reset = 1'b0;
    tick();
    checks++; if (ch_a !== 3'd0 || out_a !== 8'hA0 || valid_a !== 1'b0) begin errors++; $display("FAIL rwrap_restart: got ch=%0d out=%h valid=%b expected ch=0 out=a0 valid=0", ch_a, out_a, valid_a); end
    tick(); tick(); tick();
    checks++; if (ch_a !== 3'd0 || valid_a !== 1'b1) begin errors++; $display("FAIL rwrap_first_valid: got ch=%0d valid=%b expected ch=0 valid=1", ch_a, valid_a); end
    $display("reset-during-wrap restart ch_a=%0d valid_a=%b", ch_a, valid_a);
  endtask

  task automatic test_dwell1();
    int exp_ch;
    Mode = 1'b1; Hold = 1'b0;
    pulse_reset();
    for (int n = 1; n <= 9; n++) begin
      tick();
      exp_ch = (n - 1) % 7;
      checks++; if (ch_b !== 3'(exp_ch)) begin errors++; $display("FAIL dwell1_ch n=%0d: got %0d expected %0d", n, ch_b, exp_ch); end
      checks++; if (out_b !== pat_b[exp_ch]) begin errors++; $display("FAIL dwell1_out n=%0d: got %b expected %b", n, out_b, pat_b[exp_ch]); end
      checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL dwell1_valid n=%0d: got %b expected 1", n, valid_b); end
      checks++; if (wrap_b !== (n == 8)) begin errors++; $display("FAIL dwell1_wrap n=%0d: got %b expected %b", n, wrap_b, (n == 8)); end
      $display("dwell1 n=%0d ch_b=%0d out_b=%b valid_b=%b wrap_b=%b", n, ch_b, out_b, valid_b, wrap_b);
    end
    Hold = 1'b1;
    tick();
    checks++; if (ch_b !== 3'd1 || valid_b !== 1'b0) begin errors++; $display("FAIL dwell1_hold: got ch=%0d valid=%b expected ch=1 valid=0", ch_b, valid_b); end
    Hold = 1'b0;
  endtask

`ifdef SCAN_MUX_MASK_EN
  task automatic test_mask();
    logic [2:0] seq [4];
    seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd0;
    in_b = 7'b1111111;
    mask_b = 7'b0100101;
    Mode = 1'b1; Hold = 1'b0;
    pulse_reset();
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (ch_b !== seq[n]) begin errors++; $display("FAIL mask_ch n=%0d: got %0d expected %0d", n, ch_b, seq[n]); end
      checks++; if (out_b !== 1'b1 || valid_b !== 1'b1) begin errors++; $display("FAIL mask_out n=%0d: got out=%b valid=%b expected 1 1", n, out_b, valid_b); end
      checks++; if (wrap_b !== (n == 3)) begin errors++; $display("FAIL mask_wrap n=%0d: got %b expected %b", n, wrap_b, (n == 3)); end
      $display("mask n=%0d ch_b=%0d wrap_b=%b", n, ch_b, wrap_b);
    end
    mask_b = 7'b0000000;
    tick();
    checks++; if (ch_b !== 3'd0 || out_b !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL mask_zero: got ch=%0d out=%b valid=%b expected 0 0 0", ch_b, out_b, valid_b); end
    mask_b = 7'b0100101;
    Mode = 1'b0; MuxSelect = 3'd1;
    tick(); tick();
    checks++; if (ch_b !== 3'd1 || out_b !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL mask_manual_off: got ch=%0d out=%b valid=%b expected 1 0 0", ch_b, out_b, valid_b); end
    MuxSelect = 3'd2;
    tick(); tick();
    checks++; if (out_b !== 1'b1 || valid_b !== 1'b1) begin errors++; $display("FAIL mask_manual_on: got out=%b valid=%b expected 1 1", out_b, valid_b); end
    in_b = pat_b;
    mask_b = 7'b1111111;
  endtask
`endif

  initial begin
    Reset = 1'b1; Mode = 1'b0; Hold = 1'b0; MuxSelect = 3'd0;
`ifdef SCAN_MUX_MASK_EN
    mask_a = 7'b1111111;
    mask_b = 7'b1111111;
`endif
    init_inputs();
    test_reset();
    test_manual();
    test_manual_oob();
    test_scan();
    test_hold();
    test_reset_during_wrap();
    test_dwell1();
`ifdef SCAN_MUX_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
